bsg_tx_modulator: RTL and testbench

BSG_TX_MODULATOR -- requirements
Module: bsg_tx_modulator

---
 rtl/bsg_tx_modulator_pkg.sv | 29 ++
 rtl/bsg_tx_modulator_fifo2.sv | 52 +++++
 rtl/bsg_tx_modulator.sv | 143 ++++++++++++++
 tb/tb_bsg_tx_modulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_tx_modulator_pkg.sv
// bsg_pkg: shared types and defaults for the BSG transmit modulator.
//   state_t      : frame FSM states (idle, start symbol, data bits)
//   DEF_*        : default OUT sample levels and cycles per half-bit
//   half_lvl()   : maps a Manchester bit/phase pair onto an output level
package bsg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [7:0] DEF_HI_LVL   = 8'hFF;
  localparam logic [7:0] DEF_LO_LVL   = 8'h00;
  localparam logic [7:0] DEF_IDLE_LVL = 8'h80;
  localparam int         DEF_SPB      = 4;

  // Bit index of the LSB data bit: index 0 is the start symbol, 1..8 are data.
  localparam logic [3:0] LAST_BIT = 4'd8;

  // Manchester: a 1 is high-then-low, a 0 is low-then-high.
  function automatic logic [7:0] half_lvl(input logic       bitv,
                                          input logic       phase,
                                          input logic [7:0] hi,
                                          input logic [7:0] lo);
    return (bitv ^ phase) ? hi : lo;
  endfunction

endpackage

// File: rtl/bsg_tx_modulator_fifo2.sv
// bsg_fifo2: 2-deep x 8-bit FIFO feeding the modulator.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   push, din   : write din when push=1 (ignored when full)
//   pop, dout   : dout is the head; pop=1 drops it (ignored when empty)
//   count       : occupancy 0..2; full / empty flags derived from it
// Simultaneous push and pop keeps count and preserves order.
module bsg_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bsg_tx_modulator.sv
// bsg_tx_modulator: Manchester-modulates buffered bytes onto an 8-bit
// sample stream. Each frame is a start symbol (0) then 8 data bits MSB
// first, each half-bit held for SPB cycles.
//   G_CLK_TX   : sole clock
//   reset      : synchronous, active-low
//   tx_enable  : permits a new frame to start (never truncates one)
//   data_in / data_valid / data_ready : byte input handshake
//   OUT        : registered sample stream (IDLE_LVL when not sending)
//   busy       : high while OUT carries frame samples
//   byte_done  : one-cycle pulse in the cycle after a frame's last sample
module bsg_tx_modulator
  import bsg_pkg::*;
#(
  parameter int         SPB      = DEF_SPB,
  parameter logic [7:0] HI_LVL   = DEF_HI_LVL,
  parameter logic [7:0] LO_LVL   = DEF_LO_LVL,
  parameter logic [7:0] IDLE_LVL = DEF_IDLE_LVL
) (
  input  logic       G_CLK_TX,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] OUT,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [7:0] SPB_M1 = 8'(SPB - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] out_q, out_d;
  logic       done_q, done_d;
  logic       load;
  logic       pop;
  logic       push;
  logic       has_byte;
  logic [7:0] fifo_head;
  logic [1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;

  assign data_ready = reset & ~fifo_full;
  assign push       = data_valid & data_ready;
  assign has_byte   = (fifo_count != 2'd0) & ~fifo_empty;

  bsg_fifo2 u_fifo (
    .clk   (G_CLK_TX),
    .reset (reset),
    .push  (push),
    .din   (data_in),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The registers describe the sample currently on OUT; the next-state
  // values therefore directly select the next sample level, which is what
  // lets the first start sample appear on the same edge as the pop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    out_d   = IDLE_LVL;

    case (state_q)
      ST_IDLE: begin
        if (tx_enable && has_byte) load = 1'b1;
      end
      ST_START, ST_DATA: begin
        if (cnt_q == SPB_M1) begin
          cnt_d   = 8'd0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == LAST_BIT) begin
              done_d = 1'b1;
              if (tx_enable && has_byte) load = 1'b1;
              else                       state_d = ST_IDLE;
            end else begin
              bit_d   = bit_q + 4'd1;
              state_d = ST_DATA;
              // The start symbol consumes no data bit, so shift only
              // after a data bit.
              if (state_q == ST_DATA) shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      state_d = ST_START;
      cnt_d   = 8'd0;
      phase_d = 1'b0;
      bit_d   = 4'd0;
      shreg_d = fifo_head;
    end

    if (state_d != ST_IDLE)
      out_d = half_lvl((state_d == ST_DATA) & shreg_d[7], phase_d, HI_LVL, LO_LVL);
  end

  always_ff @(posedge G_CLK_TX) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
      bit_q   <= 4'd0;
      shreg_q <= 8'd0;
      out_q   <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign OUT       = out_q;
  assign busy      = (state_q != ST_IDLE);
  assign byte_done = done_q;

endmodule

// File: tb/tb_bsg_tx_modulator.sv
module tb_bsg_tx_modulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] out_s;
  logic       busy;
  logic       byte_done;

  always #5 clk = ~clk;

  bsg_tx_modulator #(.SPB(4)) dut (
    .G_CLK_TX   (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .OUT        (out_s),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  // One expected frame: 18 half-bit levels (1 = high), whether it must
  // follow the previous frame with no idle cycle, and (if nonzero) the
  // edge count at which its first sample must be visible.
  typedef struct {
    logic [17:0] hb;
    bit          contig;
    int          start_edge;
  } frame_t;

  frame_t sb_q[$];
  frame_t cur;
  int     n_vec = 0;
  int     n_err = 0;
  int     edge_cnt = 0;
  int     fidx = -1;
  int     idle_run = 0;
  bit     done_exp = 1'b0;
  bit     prev_rst_low = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [17:0] manch(input logic [7:0] b);
    logic [17:0] h;
    h[17:16] = 2'b01;
    for (int i = 0; i < 8; i++) h[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
    return h;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (prev_rst_low) begin
      chk("rst_out", out_s, 8'h80);
      chk("rst_busy", busy, 0);
      chk("rst_done", byte_done, 0);
      sb_q.delete();
      fidx     = -1;
      done_exp = 1'b0;
      idle_run = 1000;
    end else begin
      chk("byte_done", byte_done, done_exp);
      done_exp = 1'b0;
      if (busy === 1'b1) begin
        if (fidx < 0) begin
          chk("frame_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            cur  = sb_q.pop_front();
            fidx = 0;
            if (cur.contig) chk("gapless", idle_run, 0);
            if (cur.start_edge > 0) chk("start_edge", edge_cnt, cur.start_edge);
          end
        end
        if (fidx >= 0) begin
          chk($sformatf("out[%0d]", fidx), out_s, cur.hb[17 - fidx/4] ? 8'hFF : 8'h00);
          fidx++;
          if (fidx == 72) begin
            fidx     = -1;
            done_exp = 1'b1;
            idle_run = 0;
          end
        end
      end else begin
        chk("frame_complete", fidx < 0, 1);
        fidx = -1;
        chk("idle_out", out_s, 8'h80);
        idle_run++;
      end
    end
    if (reset === 1'b0) chk("ready_in_rst", data_ready, 0);
    prev_rst_low = (reset !== 1'b1);
  end

  // Offer a byte until accepted; the expectation is queued on acceptance.
  task automatic send(input logic [7:0] b, input logic [17:0] hb, input bit contig, input bit lat);
    bit     ok = 1'b0;
    frame_t f;
    data_in    = b;
    data_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (data_ready === 1'b1) begin
        f.hb         = hb;
        f.contig     = contig;
        f.start_edge = lat ? edge_cnt + 2 : 0;
        sb_q.push_back(f);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    chk($sformatf("accept_%h", b), ok, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || fidx >= 0) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", sb_q.size() + ((fidx >= 0) ? 1 : 0), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fidx(input int n);
    int t = 0;
    while (fidx < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("reach_%0d", n), fidx >= n, 1);
  endtask

  initial begin
    int t;
    reset = 1'b0; tx_enable = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single A5 frame, hand-expanded half-bits
    tx_enable = 1'b1;
    send(8'hA5, 18'b01_10_01_10_01_01_10_01_10, 1'b0, 1'b1);
    drain();

    // Back-to-back 00 then FF
    send(8'h00, manch(8'h00), 1'b0, 1'b1);
    send(8'hFF, manch(8'hFF), 1'b1, 1'b0);
    drain();

    // Buffer while disabled; third byte must wait
    tx_enable = 1'b0;
    send(8'h11, manch(8'h11), 1'b0, 1'b0);
    send(8'h22, manch(8'h22), 1'b1, 1'b0);
    data_in = 8'h33; data_valid = 1'b1;
    repeat (4) begin @(negedge clk); chk("ready_full", data_ready, 0); end
    @(posedge clk); #1;
    tx_enable = 1'b1;
    sb_q[0].start_edge = edge_cnt + 1;
    send(8'h33, manch(8'h33), 1'b1, 1'b0);
    drain();

    // Drop enable mid-frame: frame completes, next byte held
    send(8'hC3, manch(8'hC3), 1'b0, 1'b1);
    send(8'h5A, manch(8'h5A), 1'b0, 1'b0);
    wait_fidx(20);
    tx_enable = 1'b0;
    t = 0;
    while (fidx >= 0 && t < 300) begin @(posedge clk); #1; t++; end
    chk("frame_end", fidx < 0, 1);
    repeat (8) begin @(negedge clk); chk("no_restart", busy, 0); end
    @(posedge clk); #1;
    tx_enable = 1'b1;
    chk("held_bytes", sb_q.size(), 1);
    if (sb_q.size() > 0) sb_q[0].start_edge = edge_cnt + 1;
    drain();

    // Reset mid-frame: abort, no pulse, FIFO flushed
    send(8'hE7, manch(8'hE7), 1'b0, 1'b1);
    send(8'h3C, manch(8'h3C), 1'b1, 1'b0);
    wait_fidx(30);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", data_ready, 1);
    repeat (10) begin @(negedge clk); chk("fifo_empty_after_rst", busy, 0); end
    @(posedge clk); #1;

    // Normal operation after reset
    send(8'h96, manch(8'h96), 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
